// File: rtl/register_file_sb_pkg.sv
// Shared defaults and constants for the register file and its scoreboard counters.
package register_file_sb_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int AW_DEF     = 5;
  localparam int PEND_W_DEF = 2;

  localparam logic [AW_DEF-1:0] REG_ZERO = 5'd0;

  // Largest in-flight writer count a PEND_W-bit counter can track.
  function automatic int pend_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/register_file_sb_pend_ctr.sv
// Pending-writer counter for one register: allocate increments, writeback retires.
// Updates land on the next edge; flush and reset clear it, and inc+dec together cancel.
module rf_pend_ctr
  import register_file_sb_pkg::*;
#(
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] cnt,
  output logic              is_max,
  output logic              is_zero
);

  logic [PEND_W-1:0] cnt_q;
  logic [PEND_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      cnt_d = cnt_q + PEND_W'(1);
    end else if (dec && !inc) begin
      cnt_d = cnt_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign is_max  = &cnt_q;
  assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/register_file_sb.sv
// Integer register file with NUM_RD bypassed combinational reads and a pending-write scoreboard.
// Reads are 0-cycle; writes and scoreboard updates show from the next edge; a full counter refuses alloc.
module register_file_sb
  import register_file_sb_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = 32,
  parameter int AW     = AW_DEF,
  parameter int NUM_RD = 2,
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_pending,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   alloc_en,
  input  logic [AW-1:0]          alloc_addr,
  output logic                   alloc_ok,
  input  logic                   flush,
  output logic                   err_underflow
);

  localparam logic [AW-1:0]     ZERO_A = AW'(REG_ZERO);
  localparam logic [PEND_W-1:0] ONE_C  = PEND_W'(1);

  logic [XLEN-1:0]   mem_q    [NREGS];
  logic [PEND_W-1:0] cnt      [NREGS];
  logic              cnt_max  [NREGS];
  logic              cnt_zero [NREGS];
  logic              wr_live;
  logic              err_d;
  logic              err_q;

  assign wr_live  = wr_en && (wr_addr != ZERO_A);
  assign alloc_ok = alloc_en && !reset && !flush && (alloc_addr != ZERO_A) && !cnt_max[alloc_addr];

  always_comb begin
    err_d = err_q;
    if (wr_live && cnt_zero[wr_addr] && !flush) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_underflow = err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= '0;
      end
    end else if (wr_live) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // x0 never holds a writer: it reads as permanently empty and permanently full.
  assign cnt[0]      = '0;
  assign cnt_max[0]  = 1'b1;
  assign cnt_zero[0] = 1'b1;

  for (genvar r = 1; r < NREGS; r++) begin : g_ctr
    rf_pend_ctr #(
      .PEND_W (PEND_W)
    ) u_ctr (
      .clock   (clock),
      .reset   (reset),
      .flush   (flush),
      .inc     (alloc_ok && (alloc_addr == AW'(r))),
      .dec     (wr_live && (wr_addr == AW'(r)) && !cnt_zero[r]),
      .cnt     (cnt[r]),
      .is_max  (cnt_max[r]),
      .is_zero (cnt_zero[r])
    );
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;

    assign a   = rd_addr[i*AW +: AW];
    assign hit = wr_en && (wr_addr == a);

    assign rd_data[i*XLEN +: XLEN] = (reset || (a == ZERO_A)) ? '0 :
                                     hit                      ? wr_data : mem_q[a];
    // The last retiring writer hands its value over the bypass, so it no longer counts.
    assign rd_pending[i] = !reset && !cnt_zero[a] && !(hit && (cnt[a] == ONE_C));
  end

endmodule
